// File: rtl/reconfig_request_master.sv
// -----------------------------------------------------------------------------
// reconfig_request_master
//
// Avalon-MM initiator that pulses the single-bit reconfiguration-request PIO.
// A start strobe (accepted only while idle) runs a fixed sequence:
//   1. Write the PIO direction register (address 1) with 1.
//   2. Write the PIO data register (address 0) with 1.
//   3. Hold the request for PULSE_CYCLES cycles while reading the pin back.
//   4. Write the data register with 0.
//   5. Optionally write the direction register back to 0.
// Completion is signalled with a one-cycle done pulse. Readback and abort
// status are held until the next start.
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   start           one-cycle run request (sampled in idle only)
//   abort           level; forces an early, safe exit from the pulse
//   av_*            Avalon-MM master toward the PIO s1 slave (no waitrequest)
//   busy            high from the first bus cycle through the done cycle
//   done            one-cycle completion pulse
//   readback_ok     pin read back as 1 at the end of the hold
//   aborted         last sequence was cut short by abort
// -----------------------------------------------------------------------------
module reconfig_request_master #(
  parameter int PULSE_CYCLES = 16,
  parameter int READ_LATENCY = 1,
  parameter int RELEASE_DIR  = 1,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] av_address,
  output logic       av_chipselect,
  output logic       av_write_n,
  output logic       av_writedata,
  input  logic       av_readdata,
  output logic       busy,
  output logic       done,
  output logic       readback_ok,
  output logic       aborted
);

  // The hold must cover the slave read latency plus one cycle so the sampled
  // readdata reflects the request bit. Too-short settings are stretched.
  localparam int HOLD_LEN = (PULSE_CYCLES >= READ_LATENCY + 1) ? PULSE_CYCLES
                                                               : READ_LATENCY + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR, S_ASSERT, S_HOLD, S_DEASSERT, S_RELEASE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_q, addr_d;
  logic             cs_q, cs_d;
  logic             wn_q, wn_d;
  logic             wd_q, wd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rb_q, rb_d;
  logic             ab_q, ab_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 2'd0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rb_q    <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rb_q    <= rb_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rb_d    = rb_q;
    ab_d    = ab_q;
    addr_d  = 2'd0;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    wd_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIR;
          rb_d    = 1'b0;
          ab_d    = 1'b0;
        end
      end
      // Abort during a write lets that write finish; the deassert write that
      // follows guarantees the request pin ends low.
      S_DIR: begin
        if (abort) begin
          state_d = S_DEASSERT;
          ab_d    = 1'b1;
        end else begin
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (abort) begin
          state_d = S_DEASSERT;
          ab_d    = 1'b1;
        end else begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_DEASSERT;
          ab_d    = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_DEASSERT;
          rb_d    = av_readdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DEASSERT: state_d = (RELEASE_DIR != 0) ? S_RELEASE : S_DONE;
      S_RELEASE:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they appear registered
    // in the same cycle the state register enters that state.
    unique case (state_d)
      S_DIR:      begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd1; wd_d = 1'b1; end
      S_ASSERT:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd0; wd_d = 1'b1; end
      S_HOLD:     begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 2'd0; end
      S_DEASSERT: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd0; wd_d = 1'b0; end
      S_RELEASE:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd1; wd_d = 1'b0; end
      default:    ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign readback_ok   = rb_q;
  assign aborted       = ab_q;

endmodule

// File: doc/reconfig_request_master.md
Name: reconfig_request_master

Overview:
- Avalon-MM initiator that drives the single-bit reconfiguration-request PIO slave.
- On a `start` strobe it runs a fixed sequence:
  - enable the PIO output driver (direction register, address 1);
  - assert the request bit (data register, address 0);
  - hold it for a programmable pulse width while reading the pin back;
  - deassert the request bit;
  - optionally release the driver.
- Sits between local control logic (or the UDP command decoder) and the PIO's s1 slave.
- Reports completion and readback status to the control logic.

Parameters:
- PULSE_CYCLES, 16, cycles the request bit is held high (S_HOLD length); must be >= READ_LATENCY+1.
- READ_LATENCY, 1, slave read latency in cycles (readdata registered from address).
- RELEASE_DIR, 1, 1 = write direction register back to 0 after the pulse; 0 = leave the driver enabled.
- CNT_W, 16, hold counter width; PULSE_CYCLES < 2**CNT_W.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run the sequence; sampled only in S_IDLE.
- abort  input  1  level; forces a safe exit from S_HOLD.
- av_address  output  2  slave address.
- av_chipselect  output  1  slave select.
- av_write_n  output  1  active-low write strobe.
- av_writedata  output  1  write data.
- av_readdata  input  1  slave readdata (registered in slave).
- busy  output  1  high from the first bus cycle until S_DONE inclusive.
- done  output  1  one-cycle completion pulse.
- readback_ok  output  1  pin read back as 1 during the hold; valid when done=1, held until the next start.
- aborted  output  1  last sequence was aborted; valid when done=1, held until the next start.

Behaviour:
- Reset (asynchronous, reset_n low) values:
  - Bus: av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - Status: busy=0, done=0, readback_ok=0, aborted=0.
  - Control: state=S_IDLE, counter=0.
- All outputs are registered.
- Bus write: exactly one cycle with av_chipselect=1, av_write_n=0. The slave has no waitrequest, so there are no wait states.
- Bus read: av_chipselect=1, av_write_n=1, address held stable.
- S_IDLE:
  - Bus outputs at reset values.
  - start=1 → S_DIR; clear readback_ok and aborted.
- S_DIR (1 cycle): write address 1, data 1 → S_ASSERT.
- S_ASSERT (1 cycle): write address 0, data 1 → S_HOLD; counter loaded with PULSE_CYCLES-1.
- S_HOLD (PULSE_CYCLES cycles):
  - Read address 0; counter decrements each cycle.
  - When counter==0: register readback_ok <= av_readdata, then → S_DEASSERT. The address has been stable for >= READ_LATENCY+1 cycles, so readdata is valid.
- S_DEASSERT (1 cycle): write address 0, data 0 → S_RELEASE if RELEASE_DIR=1, else S_DONE.
- S_RELEASE (1 cycle): write address 1, data 0 → S_DONE.
- S_DONE (1 cycle):
  - Bus idle (chipselect=0).
  - done=1, busy=1.
  - → S_IDLE.
- Timing: start sampled at edge E0 gives S_DIR in cycle 1 and done high in cycle PULSE_CYCLES+5 (RELEASE_DIR=1) or PULSE_CYCLES+4 (RELEASE_DIR=0).
- Simultaneous / boundary events:
  - start while busy: ignored, not queued.
  - start coincident with done: ignored; start is accepted only in S_IDLE.
  - abort in S_DIR or S_ASSERT: completes the current single-cycle write, then → S_DEASSERT; aborted=1; readback_ok stays 0.
  - abort in S_HOLD: → S_DEASSERT next cycle; aborted=1; readback_ok not updated.
  - abort in S_DEASSERT, S_RELEASE or S_DONE: ignored (already exiting).
  - abort in S_IDLE: ignored.
  - The deassert write always occurs after a request-bit assert, so the pin is never left high.
- Counter wrap: not possible; loaded once per sequence and stopped at 0.
- Reset mid-sequence: outputs go to reset values immediately. The slave's own reset drives its data and direction to 0; there is no recovery write.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release, start=0 for 20 cycles → chipselect never 1, busy=0, done=0.
- Nominal (PULSE_CYCLES=4, RELEASE_DIR=1, slave model loops pin back):
  - start pulse → writes (addr1,1), (addr0,1); 4 read cycles on addr0; writes (addr0,0), (addr1,0).
  - done pulses in cycle 9 with readback_ok=1 and aborted=0.
- Stuck-low pin: slave model forces av_readdata=0, same run → done in cycle 9 with readback_ok=0 and the full write sequence unchanged.
- Abort in hold: abort=1 in the second S_HOLD cycle → next cycle writes (addr0,0), then (addr1,0); done with aborted=1, readback_ok=0.
- Start while busy: second start in S_HOLD and another coincident with done → exactly one sequence runs, one done pulse.
- Reset mid-hold: reset_n low during S_HOLD → chipselect=0, write_n=1, busy=0 asynchronously; after release the next start runs a full nominal sequence.
